tm_window_sched: RTL and testbench

//  Round-robin scheduler that shares one measurement-window gate generator among
//  NCH requesters. Grants one channel, fires a 1-clk start strobe to the gate,

---
 rtl/tm_window_sched.sv | 137 +++++++++++++
 tb/tb_tm_window_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tm_window_sched.sv
// Round-robin arbiter that lends a single Tm gate generator to NCH channels:
// grant, 1-clk start strobe, follow tm through rise and fall, then pulse done.
module tm_window_sched #(
    parameter int NCH  = 4,
    parameter int CW   = 2,
    parameter int TO_W = 8,
    parameter int TO   = 200
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ce,
    input  logic [NCH-1:0] req,
    input  logic           tm,
    output logic           st,
    output logic [NCH-1:0] gnt,
    output logic [CW-1:0]  ch,
    output logic           busy,
    output logic [NCH-1:0] done,
    output logic           err
);
    typedef enum logic [1:0] {IDLE, WAIT_RISE, WAIT_FALL} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO - 1);
    localparam logic [CW-1:0]   RR_RST  = CW'(NCH - 1);

    state_t          state_q, state_d;
    logic [NCH-1:0]  gnt_q, gnt_d;
    logic [NCH-1:0]  done_q, done_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [CW-1:0]   rr_q, rr_d;
    logic            busy_q, busy_d;
    logic            st_q, st_d;
    logic            err_q, err_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic            pick_vld;
    logic [CW-1:0]   pick_idx;
    logic [CW-1:0]   scan_idx;

    // Scan from the farthest offset down so the nearest requester after rr is written last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int i = NCH; i >= 1; i--) begin
            scan_idx = CW'((int'(rr_q) + i) % NCH);
            if (req[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ch_d     = ch_q;
        rr_d     = rr_q;
        busy_d   = busy_q;
        to_cnt_d = to_cnt_q;
        st_d     = 1'b0;
        done_d   = '0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    ch_d            = pick_idx;
                    busy_d          = 1'b1;
                    st_d            = 1'b1;
                    to_cnt_d        = '0;
                    state_d         = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                // A rising tm outranks a timeout landing on the same edge.
                if (tm) begin
                    state_d = WAIT_FALL;
                end else if (ce) begin
                    if (to_cnt_q == TO_LAST) begin
                        done_d[ch_q] = 1'b1;
                        err_d        = 1'b1;
                        gnt_d        = '0;
                        busy_d       = 1'b0;
                        rr_d         = ch_q;
                        state_d      = IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            WAIT_FALL: begin
                if (!tm) begin
                    done_d[ch_q] = 1'b1;
                    gnt_d        = '0;
                    busy_d       = 1'b0;
                    rr_d         = ch_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            ch_q     <= '0;
            rr_q     <= RR_RST;
            busy_q   <= 1'b0;
            st_q     <= 1'b0;
            err_q    <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            ch_q     <= ch_d;
            rr_q     <= rr_d;
            busy_q   <= busy_d;
            st_q     <= st_d;
            err_q    <= err_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    assign st   = st_q;
    assign gnt  = gnt_q;
    assign ch   = ch_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_tm_window_sched.sv
// Scoreboard bench for tm_window_sched: directed stimulus pushes expected grant/done
// events, a negedge monitor pops and compares them as the scheduler emits them.
module tb_tm_window_sched;
    localparam int NCH = 4, CW = 2, TO_W = 8, TO = 20, NP = 8;

    logic           clk = 1'b0, rst_n = 1'b0, ce = 1'b0, tm = 1'b0;
    logic [NCH-1:0] req = '0;
    logic           st, busy, err;
    logic [NCH-1:0] gnt, done;
    logic [CW-1:0]  ch;

    always #5 clk = ~clk;

    tm_window_sched #(.NCH(NCH), .CW(CW), .TO_W(TO_W), .TO(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .req(req), .tm(tm),
        .st(st), .gnt(gnt), .ch(ch), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        bit             is_done;
        logic [NCH-1:0] vec;
        bit             err;
    } ev_t;
    ev_t exp_q[$];

    int n_chk = 0, n_pass = 0;
    bit mon_en = 0, b2b_chk = 0, pend_after = 0, stuck = 0;
    int cyc = 0, last_done_cyc = -1, ce_cnt = 0, np_cnt = 0, ce_div = 0;
    logic st_prev = 1'b0, tm_h1 = 1'b0, tm_h2 = 1'b0;

    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_ev(input bit is_done, input logic [NCH-1:0] v, input bit e);
        ev_t x;
        x.is_done = is_done;
        x.vec     = v;
        x.err     = e;
        exp_q.push_back(x);
    endtask

    task automatic push_win(input logic [NCH-1:0] v, input bit e);
        push_ev(1'b0, v, 1'b0);
        push_ev(1'b1, v, e);
    endtask

    // Gate generator model: tm rises with st and stays open NP ce ticks; ce every 4 clk.
    always begin
        @(posedge clk); #1;
        if (!rst_n) begin
            tm     = 1'b0;
            np_cnt = 0;
        end else begin
            if (tm && ce) begin
                np_cnt++;
                if (np_cnt == NP) tm = 1'b0;
            end
            if (st === 1'b1 && !stuck && !tm) begin
                tm     = 1'b1;
                np_cnt = 0;
            end
        end
        ce_div = (ce_div + 1) % 4;
        ce     = (ce_div == 3);
    end

    always @(negedge clk) begin : mon
        ev_t e;
        if (mon_en) begin
            cyc++;
            if (pend_after) begin
                chk("pulse_1clk", done == '0 && !err, {done, err}, 0);
                pend_after = 0;
            end
            if (err && done == '0) chk("err_without_done", 1'b0, err, 0);
            if (st) begin
                chk("st_1clk", !st_prev, st_prev, 0);
                if (exp_q.size() == 0) chk("unexpected_grant", 1'b0, gnt, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("grant", !e.is_done && gnt == e.vec, gnt, e.vec);
                    chk("ch_busy", busy && (4'b0001 << ch) == gnt, {busy, ch}, {1'b1, e.vec});
                    if (b2b_chk && last_done_cyc >= 0)
                        chk("done_to_gnt_gap", cyc - last_done_cyc == 1, cyc - last_done_cyc, 1);
                end
                ce_cnt = ce ? 1 : 0;
            end else if (busy && ce) begin
                ce_cnt++;
            end
            if (done != '0) begin
                if (exp_q.size() == 0) chk("unexpected_done", 1'b0, done, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("done", e.is_done && done == e.vec && err == e.err, {done, err}, {e.vec, e.err});
                    chk("end_idle", !busy && gnt == '0, {busy, gnt}, 0);
                    if (e.err) chk("timeout_ticks", ce_cnt == TO, ce_cnt, TO);
                    else chk("done_after_fall", !tm_h1 && tm_h2, {tm_h2, tm_h1}, 2'b10);
                end
                last_done_cyc = cyc;
                pend_after    = 1;
            end
            st_prev = st;
            tm_h2   = tm_h1;
            tm_h1   = tm;
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic wait_done(input int c);
        for (int k = 0; k < 300; k++) begin
            step();
            if (done[c]) return;
        end
        chk("wait_done_timeout", 1'b0, c, 0);
    endtask

    task automatic wait_tm();
        for (int k = 0; k < 100; k++) begin
            step();
            if (tm) return;
        end
        chk("wait_tm_timeout", 1'b0, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_outputs", {st, gnt, done, err, busy, ch} === '0, {st, gnt, done, err, busy, ch}, 0);
        mon_en = 1;
        rst_n  = 1'b1;
        step();

        // req=1111 held: ch0,1,2,3,0 with a 1-clk gap between done and next grant
        b2b_chk       = 1;
        last_done_cyc = -1;
        push_win(4'b0001, 0); push_win(4'b0010, 0); push_win(4'b0100, 0);
        push_win(4'b1000, 0); push_win(4'b0001, 0);
        req = 4'b1111;
        wait_done(0); wait_done(1); wait_done(2); wait_done(3); wait_done(0);
        req = '0;
        step(); step();
        b2b_chk = 0;

        // serve ch1 so rr=1, then 1010 must grant ch3 before ch1
        push_win(4'b0010, 0);
        req = 4'b0010;
        wait_done(1);
        req = '0;
        step(); step();
        push_win(4'b1000, 0);
        push_win(4'b0010, 0);
        req = 4'b1010;
        wait_done(3);
        req = 4'b0010;
        wait_done(1);
        req = '0;
        step(); step();

        // single request, 1-clk grant latency
        push_win(4'b0100, 0);
        req = 4'b0100;
        step();
        chk("grant_latency", st && gnt == 4'b0100, {st, gnt}, {1'b1, 4'b0100});
        wait_done(2);
        req = '0;
        step(); step();

        // gate never rises: timeout after TO ce ticks
        stuck = 1;
        push_win(4'b0001, 1);
        req = 4'b0001;
        wait_done(0);
        req = '0;
        step(); step();
        stuck = 0;

        // reset in WAIT_FALL drops the window; pending req[1] served afterwards
        push_ev(1'b0, 4'b0100, 1'b0);
        req = 4'b0100;
        wait_tm();
        step(); step(); step();
        req   = 4'b0010;
        rst_n = 1'b0;
        step();
        chk("rst_mid_window", {st, gnt, done, err, busy, ch} === '0, {st, gnt, done, err, busy, ch}, 0);
        push_win(4'b0010, 0);
        rst_n = 1'b1;
        step();
        chk("no_done_after_rst", done == '0 && st, {done, st}, 1);
        wait_done(1);
        req = '0;
        step(); step();

        // req[3] dropped mid-window: window completes, no regrant
        push_win(4'b1000, 0);
        req = 4'b1000;
        wait_tm();
        step(); step();
        req = '0;
        wait_done(3);
        repeat (30) step();
        chk("no_regrant", !busy && gnt == '0, {busy, gnt}, 0);
        chk("queue_empty", exp_q.size() == 0, exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
